// File: rtl/fifo_flops_bypass.sv
// Flop-based synchronous FIFO with valid/ready handshakes, zero-latency bypass
// when empty, registered occupancy status and next-cycle status predictions.
module fifo_flops_bypass #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 13,
    localparam int unsigned CW = $clog2(DEPTH + 1),
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             full_next,
    output logic             empty,
    output logic             empty_next,
    output logic [CW-1:0]    items,
    output logic [CW-1:0]    items_next,
    output logic [CW-1:0]    slots,
    output logic [CW-1:0]    slots_next
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             push_fire;
    logic             pop_fire;
    logic             bypass;
    logic             do_write;
    logic             do_read;

    // Handshakes and bypass qualification
    always_comb begin
        push_ready = !full;
        pop_valid  = !empty || push_valid;
        pop_data   = empty ? push_data : mem[rd_ptr];
        push_fire  = push_valid && push_ready;
        pop_fire   = pop_valid && pop_ready;
        bypass     = empty && push_fire && pop_fire;
        do_write   = push_fire && !bypass;
        do_read    = pop_fire && !bypass;
    end

    // Next-cycle occupancy predictions
    always_comb begin
        items_next = items + CW'(do_write) - CW'(do_read);
        slots_next = CW'(DEPTH) - items_next;
        full_next  = (items_next == CW'(DEPTH));
        empty_next = (items_next == CW'(0));
    end

    // Pointers wrap at DEPTH-1, not at a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (do_read) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
        end
    end

    // Registered status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            items <= '0;
            slots <= CW'(DEPTH);
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            items <= items_next;
            slots <= slots_next;
            full  <= full_next;
            empty <= empty_next;
        end
    end

    // Storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: tb/tb_fifo_flops_bypass.sv
// Self-checking bench for fifo_flops_bypass: directed steps plus random traffic
// compared against a queue-based reference model.
module tb_fifo_flops_bypass;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 13;
    localparam int unsigned CW    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             push_valid;
    logic             push_ready;
    logic [WIDTH-1:0] push_data;
    logic             pop_valid;
    logic             pop_ready;
    logic [WIDTH-1:0] pop_data;
    logic             full;
    logic             full_next;
    logic             empty;
    logic             empty_next;
    logic [CW-1:0]    items;
    logic [CW-1:0]    items_next;
    logic [CW-1:0]    slots;
    logic [CW-1:0]    slots_next;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] model_q [$];

    fifo_flops_bypass #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_data  (push_data),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .pop_data   (pop_data),
        .full       (full),
        .full_next  (full_next),
        .empty      (empty),
        .empty_next (empty_next),
        .items      (items),
        .items_next (items_next),
        .slots      (slots),
        .slots_next (slots_next)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs after negedge, check against the model, clock, update model
    task automatic step(input logic pv, input logic [WIDTH-1:0] pd, input logic pr);
        int  n;
        int  n_next;
        bit  exp_pv;
        bit  pfire;
        bit  qfire;
        bit  byp;
        push_valid = pv;
        push_data  = pd;
        pop_ready  = pr;
        #1;
        n      = model_q.size();
        exp_pv = (n != 0) || pv;
        pfire  = pv && (n < int'(DEPTH));
        qfire  = exp_pv && pr;
        byp    = (n == 0) && pfire && qfire;
        n_next = byp ? n : n + int'(pfire) - int'(qfire);
        chk("push_ready", 32'(push_ready), 32'(n != int'(DEPTH)));
        chk("pop_valid", 32'(pop_valid), 32'(exp_pv));
        if (exp_pv) chk("pop_data", 32'(pop_data), (n == 0) ? 32'(pd) : 32'(model_q[0]));
        chk("items", 32'(items), 32'(n));
        chk("slots", 32'(slots), 32'(int'(DEPTH) - n));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("full", 32'(full), 32'(n == int'(DEPTH)));
        chk("items_next", 32'(items_next), 32'(n_next));
        chk("slots_next", 32'(slots_next), 32'(int'(DEPTH) - n_next));
        chk("empty_next", 32'(empty_next), 32'(n_next == 0));
        chk("full_next", 32'(full_next), 32'(n_next == int'(DEPTH)));
        @(posedge clk);
        if (!byp) begin
            if (qfire) void'(model_q.pop_front());
            if (pfire) model_q.push_back(pd);
        end
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        push_valid = 1'b0;
        push_data  = '0;
        pop_ready  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        step(1'b0, 8'h00, 1'b0);

        // Bypass on empty
        step(1'b1, 8'hA5, 1'b1);

        // Fill to full, then an ignored push while full
        for (int i = 0; i < int'(DEPTH); i++) step(1'b1, 8'(i), 1'b0);
        step(1'b1, 8'hEE, 1'b0);
        step(1'b1, 8'hEF, 1'b1);

        // Drain in order
        while (model_q.size() > 0) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // Next-state predictions
        step(1'b1, 8'h55, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h10, 1'b0);
        step(1'b1, 8'hAB, 1'b1);

        // Continuous push+pop across several pointer wraps
        step(1'b1, 8'h20, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 8'($urandom), 1'b1);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        // Exactly five held entries, then asynchronous reset mid-cycle
        while (model_q.size() > 0) step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
        chk("items_before_rst", 32'(items), 32'd5);
        push_valid = 1'b1;
        push_data  = 8'h3C;
        pop_ready  = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_q.delete();
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_items", 32'(items), 32'd0);
        chk("rst_slots", 32'(slots), 32'(DEPTH));
        chk("rst_pop_valid", 32'(pop_valid), 32'(push_valid));
        chk("rst_pop_data", 32'(pop_data), 32'h3C);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h77, 1'b0);
        step(1'b0, 8'h00, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
